i2c_target_regs: RTL and testbench

- I2C target (slave) responder: the far end of the I2C link whose master side sits behind the core's i2c_reset control.
- Exposes a small 8-bit register bank to an external I2C master.
- Master writes a register pointer, then writes or reads data bytes; the pointer auto-increments.
- Register contents are presented in parallel to the core side, and each committed write raises a one-cycle strobe.

---
 rtl/i2c_target_regs.sv | 227 ++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// I2C target exposing a small register bank to an external master.
// The master writes a register pointer, then writes or reads bytes; the pointer auto-increments.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         NUM_REGS = 4,
    parameter int         PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_index,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [PTR_W-1:0] ptr, ptr_nx;
    logic             rw, rw_nx;
    logic             ack_hold, ack_hold_nx;
    logic             sda_oe_nx, busy_nx, wr_en;
    logic [7:0]       regs [NUM_REGS];

    logic scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start, stop, byte_done;
    logic [7:0] rx_byte;

    // Synchronizers idle high so a reset never fabricates a bus event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start     = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop      = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign rx_byte   = {shreg[6:0], sda_s2};
    assign byte_done = scl_rise && (bit_cnt == 3'd7);

    always_comb begin
        state_nx    = state;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        ptr_nx      = ptr;
        rw_nx       = rw;
        ack_hold_nx = ack_hold;
        sda_oe_nx   = sda_oe;
        busy_nx     = busy;
        wr_en       = 1'b0;
        if (stop) begin
            state_nx  = IDLE;
            sda_oe_nx = 1'b0;
            busy_nx   = 1'b0;
        end else if (start) begin
            state_nx   = ADDR;
            bit_cnt_nx = 3'd0;
            sda_oe_nx  = 1'b0;
            busy_nx    = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_nx    = ADDR_ACK;
                            busy_nx     = 1'b1;
                            rw_nx       = rx_byte[0];
                            ack_hold_nx = 1'b0;
                        end else begin
                            state_nx = IGNORE;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        ptr_nx      = rx_byte[PTR_W-1:0];
                        state_nx    = PTR_ACK;
                        ack_hold_nx = 1'b0;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shreg_nx   = rx_byte;
                        bit_cnt_nx = bit_cnt + 3'd1;
                    end
                    if (byte_done) begin
                        wr_en       = 1'b1;
                        ptr_nx      = ptr + PTR_W'(1);
                        state_nx    = WDATA_ACK;
                        ack_hold_nx = 1'b0;
                    end
                end
                // First SCL fall starts the ACK, the second ends it.
                ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ack_hold) begin
                            sda_oe_nx   = 1'b1;
                            ack_hold_nx = 1'b1;
                        end else begin
                            sda_oe_nx  = 1'b0;
                            bit_cnt_nx = 3'd0;
                            if (state == ADDR_ACK && rw) begin
                                shreg_nx  = regs[ptr];
                                sda_oe_nx = ~regs[ptr][7];
                                state_nx  = RDATA;
                            end else if (state == ADDR_ACK) begin
                                state_nx = PTR;
                            end else begin
                                state_nx = WDATA;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state_nx    = RDATA_ACK;
                            ack_hold_nx = 1'b0;
                            bit_cnt_nx  = 3'd0;
                        end
                    end
                    if (scl_fall) begin
                        shreg_nx  = {shreg[6:0], 1'b0};
                        sda_oe_nx = ~shreg[6];
                    end
                end
                // ack_hold marks that the master ACKed and another byte follows.
                RDATA_ACK: begin
                    if (scl_fall) begin
                        if (ack_hold) begin
                            shreg_nx   = regs[ptr];
                            sda_oe_nx  = ~regs[ptr][7];
                            bit_cnt_nx = 3'd0;
                            state_nx   = RDATA;
                        end else begin
                            sda_oe_nx = 1'b0;
                        end
                    end
                    if (scl_rise) begin
                        ptr_nx = ptr + PTR_W'(1);
                        if (!sda_s2) begin
                            ack_hold_nx = 1'b1;
                        end else begin
                            state_nx  = IGNORE;
                            sda_oe_nx = 1'b0;
                        end
                    end
                end
                IGNORE: sda_oe_nx = 1'b0;
                default: begin
                    state_nx  = IDLE;
                    sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_hold  <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            ptr       <= ptr_nx;
            rw        <= rw_nx;
            ack_hold  <= ack_hold_nx;
            sda_oe    <= sda_oe_nx;
            busy      <= busy_nx;
            wr_strobe <= wr_en;
            if (wr_en) wr_index <= ptr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_en) begin
            regs[ptr] <= rx_byte;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: an I2C master model drives directed and random
// transactions; a register-bank model predicts ACKs, read data, strobes and contents.
module tb_i2c_target_regs;

    localparam logic [6:0] DEV_ADDR = 7'h42;
    localparam int NUM_REGS = 4;
    localparam int PTR_W    = 2;
    localparam int Q        = 50;

    logic                  clk = 1'b0;
    logic                  reset, scl, sda_m, sda_line;
    logic                  sda_oe, wr_strobe, busy;
    logic [8*NUM_REGS-1:0] regs_flat;
    logic [PTR_W-1:0]      wr_index;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] m_regs [NUM_REGS];
    int         m_ptr;
    int         exp_q[$];
    int         obs_q[$];
    int         obs_rd = 0;
    int         busy_cycles = 0;
    logic [7:0] wbuf [8];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(DEV_ADDR), .NUM_REGS(NUM_REGS), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
        .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) obs_q.push_back(int'(wr_index) * 256 + int'(regs_flat[8*wr_index +: 8]));
        if (busy) busy_cycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_flat();
        logic [31:0] r;
        for (int i = 0; i < NUM_REGS; i++) r[8*i +: 8] = m_regs[i];
        return r;
    endfunction

    task automatic bus_start();
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #Q; scl = 1'b1; #Q; b = sda_line; #Q; scl = 1'b0; #Q;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        acked = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(~ack);
    endtask

    // Idle bus state, bank contents and the strobes seen since the last call.
    task automatic check_after(input string tag);
        checkOutput({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_regs"}, regs_flat, model_flat());
        checkOutput({tag, "_nstrobe"}, obs_q.size() - obs_rd, exp_q.size());
        while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
            checkOutput({tag, "_strobe"}, obs_q[obs_rd], exp_q.pop_front());
            obs_rd++;
        end
        exp_q.delete();
        obs_rd = obs_q.size();
    endtask

    task automatic write_txn(input string tag, input logic [6:0] addr, input int n);
        logic acked;
        logic match;
        match = (addr == DEV_ADDR);
        bus_start();
        put_byte({addr, 1'b0}, acked);
        checkOutput({tag, "_addr_ack"}, 32'(acked), 32'(match));
        for (int i = 0; i < n; i++) begin
            put_byte(wbuf[i], acked);
            checkOutput({tag, "_data_ack"}, 32'(acked), 32'(match));
            if (match) begin
                if (i == 0) begin
                    m_ptr = int'(wbuf[0]) % NUM_REGS;
                end else begin
                    m_regs[m_ptr] = wbuf[i];
                    exp_q.push_back(m_ptr * 256 + int'(wbuf[i]));
                    m_ptr = (m_ptr + 1) % NUM_REGS;
                end
            end
        end
        bus_stop();
        check_after(tag);
    endtask

    task automatic read_txn(input string tag, input logic set_ptr, input logic [7:0] p, input int n);
        logic acked;
        logic [7:0] d;
        bus_start();
        if (set_ptr) begin
            put_byte({DEV_ADDR, 1'b0}, acked);
            checkOutput({tag, "_waddr_ack"}, 32'(acked), 32'd1);
            put_byte(p, acked);
            checkOutput({tag, "_ptr_ack"}, 32'(acked), 32'd1);
            m_ptr = int'(p) % NUM_REGS;
            bus_start();
        end
        put_byte({DEV_ADDR, 1'b1}, acked);
        checkOutput({tag, "_raddr_ack"}, 32'(acked), 32'd1);
        for (int i = 0; i < n; i++) begin
            get_byte(d, i != n - 1);
            checkOutput({tag, "_rdata"}, d, m_regs[m_ptr]);
            m_ptr = (m_ptr + 1) % NUM_REGS;
        end
        checkOutput({tag, "_released"}, 32'(sda_oe), 32'd0);
        bus_stop();
        check_after(tag);
    endtask

    task automatic applyStimulus(input int count);
        int kind, n;
        for (int t = 0; t < count; t++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                write_txn("rnd_wr", DEV_ADDR, n);
            end else if (kind == 2) begin
                read_txn("rnd_rd", 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(1, 5));
            end else begin
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                write_txn("rnd_badaddr", DEV_ADDR ^ 7'(1 << $urandom_range(0, 6)), n);
            end
        end
    endtask

    initial begin
        int b0;
        logic acked;
        reset = 1'b1;
        scl   = 1'b1;
        sda_m = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        #20;
        checkOutput("reset_regs", regs_flat, 32'd0);
        checkOutput("reset_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_strobe", 32'(wr_strobe), 32'd0);
        reset = 1'b0;
        #40;

        wbuf[0] = 8'h01; wbuf[1] = 8'hA5; wbuf[2] = 8'h3C;
        write_txn("wr_basic", DEV_ADDR, 3);
        read_txn("rd_from_ptr3", 1'b0, 8'h00, 3);

        b0 = busy_cycles;
        wbuf[0] = 8'h00; wbuf[1] = 8'hFF;
        write_txn("wr_wrong_addr", 7'h43, 2);
        checkOutput("wrong_addr_busy", busy_cycles - b0, 32'd0);

        wbuf[0] = 8'h03; wbuf[1] = 8'h11; wbuf[2] = 8'h22;
        write_txn("preload", DEV_ADDR, 3);
        read_txn("rd_wrap", 1'b1, 8'h03, 2);
        read_txn("rd_ptr_after_nack", 1'b0, 8'h00, 1);

        wbuf[0] = 8'h02; wbuf[1] = 8'h10; wbuf[2] = 8'h20; wbuf[3] = 8'h30; wbuf[4] = 8'h40;
        write_txn("wr_wrap", DEV_ADDR, 5);

        bus_start();
        put_byte({DEV_ADDR, 1'b0}, acked);
        put_byte(8'h00, acked);
        m_ptr = 0;
        for (int i = 0; i < 4; i++) put_bit(i < 4);
        bus_stop();
        check_after("partial");
        wbuf[0] = 8'h01; wbuf[1] = 8'h5A;
        write_txn("after_partial", DEV_ADDR, 2);

        bus_start();
        for (int i = 7; i >= 0; i--) put_bit(i == 0 ? 1'b0 : DEV_ADDR[i-1]);
        sda_m = 1'b1;
        for (int i = 0; i < 20 && !sda_oe; i++) @(negedge clk);
        checkOutput("ack_driven", 32'(sda_oe), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("midack_reset_sda_oe", 32'(sda_oe), 32'd0);
        checkOutput("midack_reset_regs", regs_flat, 32'd0);
        #7;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        #Q; reset = 1'b0; #Q;
        scl = 1'b1; #(2*Q);
        check_after("post_reset_idle");
        wbuf[0] = 8'h02; wbuf[1] = 8'hC3; wbuf[2] = 8'h7E;
        write_txn("post_reset_wr", DEV_ADDR, 3);
        read_txn("post_reset_rd", 1'b1, 8'h02, 2);

        applyStimulus(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
